sector_mem_responder: RTL and testbench

Avalon-MM slave that answers the HPS DMA bridge's single-word `mem_read`/`mem_write` requests from a 512-byte (128 × 32-bit) sector buffer. A second local port gives the disk controller access to the same buffer. A transfer sequencer counts host accesses per sector and signals completion or protocol errors. The block sits between the HPS-side DMA bridge (initiator) and the IDE/floppy controller in `clk_sys`.

---
 rtl/sector_pkg.sv | 22 ++
 rtl/sector_ram.sv | 41 ++++
 rtl/sector_mem_responder.sv | 189 ++++++++++++++++++
 tb/tb_sector_mem_responder.sv | 355 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sector_pkg.sv
// Shared types and constants for the sector buffer responder.
package sector_pkg;

  // Default buffer depth in 32-bit words (512-byte sector).
  localparam int unsigned SECTOR_WORDS_DEF = 128;

  // Host read latency: RAM output register plus the readdata register.
  localparam int unsigned READ_LAT = 2;

  // Data returned for reads that do not belong to the armed transfer.
  localparam logic [31:0] FILL_WORD_DEF = 32'hFFFF_FFFF;

  // Transfer direction as seen from the host.
  localparam logic DIR_HOST_WR = 1'b0;
  localparam logic DIR_HOST_RD = 1'b1;

  typedef enum logic {
    IDLE  = 1'b0,
    ARMED = 1'b1
  } xfer_state_t;

endpackage

// File: rtl/sector_ram.sv
// Single-port sector RAM with registered read and byte-enable write.
// Time-shared between the host and local ports by the responder.
module sector_ram
  import sector_pkg::*;
#(
  parameter int unsigned Words = SECTOR_WORDS_DEF
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic [$clog2(Words)-1:0] i_addr,
  input  logic                     i_re,
  input  logic                     i_we,
  input  logic [3:0]               i_be,
  input  logic [31:0]              i_wdata,
  output logic [31:0]              o_rdata
);

  logic [31:0] r_mem [Words];
  logic [31:0] r_rdata;

  // Byte-lane writes; the array itself carries no reset.
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      for (int b = 0; b < 4; b++) begin
        if (i_be[b]) r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
      end
    end
  end

  // Registered read; holds its value between reads so the local port sees stable data.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rdata <= '0;
    end else if (i_re) begin
      r_rdata <= r_mem[i_addr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/sector_mem_responder.sv
// Avalon-MM slave serving single-word host accesses from a sector buffer, with a
// local port for the disk controller and a per-sector transfer sequencer.
module sector_mem_responder
  import sector_pkg::*;
#(
  parameter int unsigned SECTOR_WORDS = SECTOR_WORDS_DEF,
  parameter logic [31:0] FILL_WORD    = FILL_WORD_DEF
) (
  input  logic                            clk_sys,
  input  logic                            reset_n,
  // Host (Avalon-MM) port
  input  logic [31:0]                     mem_address,
  input  logic                            mem_read,
  input  logic                            mem_write,
  input  logic [31:0]                     mem_writedata,
  input  logic [3:0]                      mem_byteenable,
  output logic                            mem_waitrequest,
  output logic [31:0]                     mem_readdata,
  output logic                            mem_readdatavalid,
  // Local disk-controller port
  input  logic [$clog2(SECTOR_WORDS)-1:0] buf_addr,
  input  logic                            buf_rd,
  input  logic                            buf_wr,
  input  logic [31:0]                     buf_wdata,
  output logic [31:0]                     buf_rdata,
  // Transfer sequencer
  input  logic                            xfer_start,
  input  logic                            xfer_dir,
  output logic                            xfer_busy,
  output logic                            xfer_done,
  output logic                            xfer_err
);

  localparam int unsigned AW = $clog2(SECTOR_WORDS);

  logic              r_rst_done;
  xfer_state_t       r_state;
  xfer_state_t       w_state_d;
  logic              r_dir;
  logic [AW-1:0]     r_cnt;
  logic              r_err;
  logic              r_done;
  logic              r_v1;
  logic              r_fill1;
  logic              r_rdv;
  logic [31:0]       r_rdata;

  logic              w_local;
  logic              w_host_acc;
  logic              w_host_rd;
  logic              w_match;
  logic              w_match_acc;
  logic              w_last;
  logic [AW-1:0]     w_host_addr;
  logic [AW-1:0]     w_ram_addr;
  logic              w_ram_re;
  logic              w_ram_we;
  logic [3:0]        w_ram_be;
  logic [31:0]       w_ram_wdata;
  logic [31:0]       w_ram_rdata;
  logic              w_unused;

  // Holds off the host for the first clock after reset release.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) r_rst_done <= 1'b0;
    else          r_rst_done <= 1'b1;
  end

  // The local port always wins; the host is stalled rather than dropped.
  assign w_local         = buf_rd | buf_wr;
  assign mem_waitrequest = ~r_rst_done | w_local;
  assign w_host_acc      = (mem_read | mem_write) & ~mem_waitrequest;
  // A simultaneous read and write is handled as a write.
  assign w_host_rd       = mem_read & ~mem_write;
  assign w_host_addr     = mem_address[AW+1:2];
  assign w_unused        = ^{mem_address[31:AW+2], mem_address[1:0]};

  // Classify the host request against the armed transfer direction.
  always_comb begin
    w_match = 1'b0;
    if (r_state == ARMED) begin
      if (r_dir == DIR_HOST_WR) w_match = mem_write & ~mem_read;
      else                      w_match = mem_read & ~mem_write;
    end
  end

  assign w_match_acc = w_host_acc & w_match;
  assign w_last      = (r_cnt == AW'(SECTOR_WORDS - 1));

  // RAM port mux: local access first, otherwise an accepted host access.
  always_comb begin
    w_ram_addr  = w_host_addr;
    w_ram_re    = 1'b0;
    w_ram_we    = 1'b0;
    w_ram_be    = 4'h0;
    w_ram_wdata = mem_writedata;
    if (w_local) begin
      w_ram_addr  = buf_addr;
      w_ram_re    = buf_rd;
      w_ram_we    = buf_wr;
      w_ram_be    = 4'hF;
      w_ram_wdata = buf_wdata;
    end else if (w_host_acc) begin
      w_ram_re    = w_host_rd;
      w_ram_we    = mem_write & w_match;
      w_ram_be    = mem_byteenable;
    end
  end

  sector_ram #(
    .Words (SECTOR_WORDS)
  ) u_ram (
    .i_clk   (clk_sys),
    .i_rst_n (reset_n),
    .i_addr  (w_ram_addr),
    .i_re    (w_ram_re),
    .i_we    (w_ram_we),
    .i_be    (w_ram_be),
    .i_wdata (w_ram_wdata),
    .o_rdata (w_ram_rdata)
  );

  assign buf_rdata = w_ram_rdata;

  // Read-latency pipe: stage 1 rides alongside the RAM output register, stage 2 drives the host.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_v1    <= 1'b0;
      r_fill1 <= 1'b0;
      r_rdv   <= 1'b0;
      r_rdata <= '0;
    end else begin
      r_v1    <= w_host_acc & w_host_rd;
      r_fill1 <= ~w_match;
      r_rdv   <= r_v1;
      if (r_v1) r_rdata <= r_fill1 ? FILL_WORD : w_ram_rdata;
    end
  end

  assign mem_readdatavalid = r_rdv;
  assign mem_readdata      = r_rdata;

  // Sequencer state register.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_state_d;
  end

  // Sequencer next state: start (re)arms, the last matching access completes the sector.
  always_comb begin
    w_state_d = r_state;
    case (r_state)
      IDLE:    if (xfer_start) w_state_d = ARMED;
      ARMED: begin
        if (xfer_start)                 w_state_d = ARMED;
        else if (w_match_acc && w_last) w_state_d = IDLE;
      end
      default: w_state_d = IDLE;
    endcase
  end

  // Sequencer outputs.
  always_comb begin
    xfer_busy = (r_state == ARMED);
    xfer_done = r_done;
    xfer_err  = r_err;
  end

  // Sequencer datapath: direction, word count, sticky error and completion pulse.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_dir  <= DIR_HOST_WR;
      r_cnt  <= '0;
      r_err  <= 1'b0;
      r_done <= 1'b0;
    end else if (xfer_start) begin
      r_dir  <= xfer_dir;
      r_cnt  <= '0;
      r_err  <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_done <= w_match_acc & w_last;
      // Count wraps to zero on the final word, ready for the next arm.
      if (w_match_acc)              r_cnt <= r_cnt + AW'(1);
      if (w_host_acc && !w_match)   r_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sector_mem_responder.sv
// Self-checking bench: directed scenarios plus a randomized phase, all compared
// against a transaction-level model of the sector buffer and sequencer.
module tb_sector_mem_responder;

  localparam int W = 128;

  logic        clk_sys = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] mem_address;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_writedata;
  logic [3:0]  mem_byteenable;
  logic        mem_waitrequest;
  logic [31:0] mem_readdata;
  logic        mem_readdatavalid;
  logic [6:0]  buf_addr;
  logic        buf_rd;
  logic        buf_wr;
  logic [31:0] buf_wdata;
  logic [31:0] buf_rdata;
  logic        xfer_start;
  logic        xfer_dir;
  logic        xfer_busy;
  logic        xfer_done;
  logic        xfer_err;

  always #5 clk_sys = ~clk_sys;

  sector_mem_responder dut (
    .clk_sys           (clk_sys),
    .reset_n           (reset_n),
    .mem_address       (mem_address),
    .mem_read          (mem_read),
    .mem_write         (mem_write),
    .mem_writedata     (mem_writedata),
    .mem_byteenable    (mem_byteenable),
    .mem_waitrequest   (mem_waitrequest),
    .mem_readdata      (mem_readdata),
    .mem_readdatavalid (mem_readdatavalid),
    .buf_addr          (buf_addr),
    .buf_rd            (buf_rd),
    .buf_wr            (buf_wr),
    .buf_wdata         (buf_wdata),
    .buf_rdata         (buf_rdata),
    .xfer_start        (xfer_start),
    .xfer_dir          (xfer_dir),
    .xfer_busy         (xfer_busy),
    .xfer_done         (xfer_done),
    .xfer_err          (xfer_err)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: buffer contents, transfer bookkeeping, pending host reads.
  typedef struct {
    int          due;
    logic [31:0] data;
  } rd_t;

  logic [31:0] m_mem [W];
  bit          m_ready = 0;
  bit          m_armed = 0;
  bit          m_dir   = 0;
  bit          m_err   = 0;
  int          m_cnt   = 0;
  rd_t         m_rq[$];
  int          cyc     = 0;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b at cycle %0d", tag, obs, exp, cyc);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h at cycle %0d", tag, obs, exp, cyc);
    end
  endtask

  task automatic idle_inputs();
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    buf_rd     = 1'b0;
    buf_wr     = 1'b0;
    xfer_start = 1'b0;
  endtask

  task automatic host_addr(input int a);
    logic [31:0] ad;
    ad      = $urandom;
    ad[8:2] = 7'(a);
    mem_address = ad;
  endtask

  task automatic host_wr(input int a, input logic [31:0] d, input logic [3:0] be);
    host_addr(a);
    mem_write      = 1'b1;
    mem_read       = 1'b0;
    mem_writedata  = d;
    mem_byteenable = be;
  endtask

  task automatic host_rd(input int a);
    host_addr(a);
    mem_read       = 1'b1;
    mem_write      = 1'b0;
    mem_writedata  = $urandom;
    mem_byteenable = 4'($urandom);
  endtask

  task automatic loc_wr(input int a, input logic [31:0] d);
    buf_wr    = 1'b1;
    buf_rd    = 1'b0;
    buf_addr  = 7'(a);
    buf_wdata = d;
  endtask

  task automatic loc_rd(input int a);
    buf_rd   = 1'b1;
    buf_wr   = 1'b0;
    buf_addr = 7'(a);
  endtask

  // One clock: check the stall, apply the current inputs to the model, clock, compare.
  task automatic step();
    bit          exp_done;
    bit          brd_pend;
    logic [31:0] brd_exp;
    bit          wr;
    bit          match;
    int          a;
    exp_done = 0;
    brd_pend = 0;
    brd_exp  = '0;
    #1;
    if (!reset_n) begin
      chk1("waitreq_in_reset", mem_waitrequest, 1'b1);
      m_armed = 0;
      m_cnt   = 0;
      m_err   = 0;
      m_rq.delete();
    end else begin
      chk1("waitreq", mem_waitrequest, !m_ready || buf_rd || buf_wr);
      if (buf_rd || buf_wr) begin
        if (buf_rd) begin
          brd_pend = 1;
          brd_exp  = m_mem[buf_addr];
        end
        if (buf_wr) m_mem[buf_addr] = buf_wdata;
      end else if (m_ready && (mem_read || mem_write)) begin
        a     = int'(mem_address[8:2]);
        wr    = mem_write;
        match = m_armed && (wr ? (m_dir == 0 && !mem_read) : (m_dir == 1));
        if (!wr) begin
          m_rq.push_back('{due: cyc + 2, data: match ? m_mem[a] : 32'hFFFF_FFFF});
        end else if (match) begin
          for (int b = 0; b < 4; b++) begin
            if (mem_byteenable[b]) m_mem[a][8*b +: 8] = mem_writedata[8*b +: 8];
          end
        end
        if (match) begin
          m_cnt++;
          if (m_cnt == W) begin
            m_cnt    = 0;
            m_armed  = 0;
            exp_done = 1;
          end
        end else begin
          m_err = 1;
        end
      end
      if (xfer_start) begin
        m_armed  = 1;
        m_dir    = xfer_dir;
        m_cnt    = 0;
        m_err    = 0;
        exp_done = 0;
      end
    end
    @(posedge clk_sys);
    cyc++;
    m_ready = reset_n;
    #1;
    if (!reset_n) begin
      chk1("rst_rdv", mem_readdatavalid, 1'b0);
      chk32("rst_readdata", mem_readdata, 32'h0);
      chk32("rst_buf_rdata", buf_rdata, 32'h0);
      chk1("rst_busy", xfer_busy, 1'b0);
      chk1("rst_done", xfer_done, 1'b0);
      chk1("rst_err", xfer_err, 1'b0);
    end else begin
      if (m_rq.size() > 0 && m_rq[0].due == cyc) begin
        chk1("rdv", mem_readdatavalid, 1'b1);
        chk32("readdata", mem_readdata, m_rq[0].data);
        void'(m_rq.pop_front());
      end else begin
        chk1("rdv_idle", mem_readdatavalid, 1'b0);
      end
      chk1("done", xfer_done, exp_done);
      chk1("busy", xfer_busy, m_armed);
      chk1("err", xfer_err, m_err);
      if (brd_pend) chk32("buf_rdata", buf_rdata, brd_exp);
    end
  endtask

  initial begin
    logic [31:0] d;
    int          k;
    idle_inputs();
    mem_address    = '0;
    mem_writedata  = '0;
    mem_byteenable = '0;
    buf_addr       = '0;
    buf_wdata      = '0;
    xfer_dir       = 1'b0;

    // Reset values, then the one-cycle stall after release.
    repeat (3) step();
    reset_n = 1'b1;
    step();

    // Fill sector: 128 matching host writes with occasional idle gaps.
    xfer_dir = 1'b0; xfer_start = 1'b1; step(); xfer_start = 1'b0;
    for (int i = 0; i < W; i++) begin
      host_wr(i, 32'(i) * 32'h0101_0101, 4'hF);
      step();
      if (i == W - 1) chk1("fill_done", xfer_done, 1'b1);
      if ($urandom_range(3) == 0) begin
        idle_inputs();
        step();
      end
    end
    idle_inputs(); step();
    chk1("fill_err_clear", xfer_err, 1'b0);
    for (int i = 0; i < W; i++) begin
      loc_rd(i); step();
      chk32("fill_word", buf_rdata, 32'(i) * 32'h0101_0101);
    end
    idle_inputs(); step();

    // Drain sector: preload locally, then 128 back-to-back host reads.
    for (int i = 0; i < W; i++) begin
      loc_wr(i, $urandom); step();
    end
    idle_inputs();
    xfer_dir = 1'b1; xfer_start = 1'b1; step(); xfer_start = 1'b0;
    for (int i = 0; i < W; i++) begin
      host_rd(i); step();
    end
    chk1("drain_done", xfer_done, 1'b1);
    idle_inputs();
    repeat (3) step();

    // Byte enables over a locally written word.
    xfer_dir = 1'b0; xfer_start = 1'b1; step(); xfer_start = 1'b0;
    loc_wr(5, 32'h1122_3344); step(); idle_inputs();
    host_wr(5, 32'hAABB_CCDD, 4'b0101); step(); idle_inputs();
    loc_rd(5); step(); idle_inputs();
    chk32("byteen_merge", buf_rdata, 32'h11BB_33DD);

    // Local write held three cycles over a host write: stall, then accept.
    host_wr(9, $urandom, 4'hF);
    loc_wr(20, $urandom);
    for (int i = 0; i < 3; i++) begin
      #1 chk1("coll_stall", mem_waitrequest, 1'b1);
      step();
    end
    buf_wr = 1'b0;
    step();
    idle_inputs();
    // Two words already counted; 126 more must complete the sector.
    for (int i = 0; i < W - 2; i++) begin
      host_wr($urandom_range(W - 1), $urandom, 4'($urandom));
      step();
    end
    chk1("coll_done", xfer_done, 1'b1);
    idle_inputs(); step();

    // Protocol error: a read during a host-write transfer.
    xfer_dir = 1'b0; xfer_start = 1'b1; step(); xfer_start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      host_wr(i, $urandom, 4'hF); step();
    end
    host_rd(40); step(); idle_inputs();
    step();
    chk32("perr_fill", mem_readdata, 32'hFFFF_FFFF);
    chk1("perr_set", xfer_err, 1'b1);
    for (int i = 0; i < W - 3; i++) begin
      host_wr(i + 3, $urandom, 4'hF); step();
    end
    chk1("perr_cnt_kept", xfer_done, 1'b1);
    idle_inputs();
    xfer_dir = 1'b1; xfer_start = 1'b1; step(); xfer_start = 1'b0;
    chk1("perr_cleared", xfer_err, 1'b0);

    // Read and write together count as an erroneous write.
    mem_read = 1'b1; mem_write = 1'b1; mem_writedata = $urandom; step();
    idle_inputs(); repeat (2) step();
    chk1("both_err", xfer_err, 1'b1);

    // Same-word collision: local write then host read of the same word.
    xfer_dir = 1'b1; xfer_start = 1'b1; step(); xfer_start = 1'b0;
    d = $urandom;
    loc_wr(33, d); step(); idle_inputs();
    host_rd(33); step(); idle_inputs();
    step();
    chk1("samewd_rdv", mem_readdatavalid, 1'b1);
    chk32("samewd_data", mem_readdata, d);

    // Randomized mix of host, local and sequencer activity.
    for (int n = 0; n < 600; n++) begin
      idle_inputs();
      if ($urandom_range(99) < 3) begin
        xfer_start = 1'b1;
        xfer_dir   = 1'($urandom_range(1));
      end else begin
        k = $urandom_range(9);
        if (k < 4)      host_rd($urandom_range(W - 1));
        else if (k < 8) host_wr($urandom_range(W - 1), $urandom, 4'($urandom));
        else if (k == 8) begin
          host_wr($urandom_range(W - 1), $urandom, 4'hF);
          mem_read = 1'b1;
        end
        if ($urandom_range(4) == 0) begin
          if ($urandom_range(1) == 1) loc_rd($urandom_range(W - 1));
          else                        loc_wr($urandom_range(W - 1), $urandom);
        end
      end
      step();
    end
    idle_inputs();
    repeat (3) step();

    // Reset one cycle after a read is accepted: the read must vanish.
    xfer_dir = 1'b1; xfer_start = 1'b1; step(); xfer_start = 1'b0;
    host_rd(7); step(); idle_inputs();
    reset_n = 1'b0;
    #1 chk1("midrst_rdv", mem_readdatavalid, 1'b0);
    repeat (2) step();
    reset_n = 1'b1;
    #1 chk1("midrst_wait", mem_waitrequest, 1'b1);
    repeat (3) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
